// File: rtl/frame_rate_pkg.sv
// frame_rate_pkg
// Shared definitions for the frame rate controller:
//   - frc_state_t       : controller FSM state encoding
//   - DEF_*             : default reload parameters (50 MHz system clock)
//   - PERIOD_*FPS       : reload values for common frame rates at 50 MHz
package frame_rate_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_PAUSED = 2'd3
  } frc_state_t;

  // Level-0 reload (15 fps), per-level decrement, and the ~60 fps floor.
  localparam logic [31:0] DEF_BASE_PERIOD = 32'd3333332;
  localparam logic [31:0] DEF_STEP        = 32'd208333;
  localparam logic [31:0] DEF_MIN_PERIOD  = 32'd833332;

  // Counter reload values at 50 MHz (counter counts reload..0, so N-1 style).
  localparam logic [31:0] PERIOD_10FPS = 32'd4999999;
  localparam logic [31:0] PERIOD_15FPS = 32'd3333332;
  localparam logic [31:0] PERIOD_60FPS = 32'd833332;

endpackage

// File: rtl/period_lut.sv
// period_lut
// Combinational level -> reload period mapping.
//   period = BASE_PERIOD - level*STEP, clamped to MIN_PERIOD.
// The clamp decision is made by comparing level*STEP against the headroom
// (BASE_PERIOD - MIN_PERIOD) before subtracting, so the result never wraps.
// Ports:
//   level  in  LEVEL_W  current game level
//   period out 32       clamped reload value
module period_lut
  import frame_rate_pkg::*;
#(
  parameter logic [31:0] BASE_PERIOD = DEF_BASE_PERIOD,
  parameter logic [31:0] STEP        = DEF_STEP,
  parameter logic [31:0] MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int          LEVEL_W     = 4
) (
  input  logic [LEVEL_W-1:0] level,
  output logic [31:0]        period
);

  logic [31:0] offset;
  logic [31:0] headroom;

  assign offset   = 32'(level) * STEP;
  assign headroom = BASE_PERIOD - MIN_PERIOD;

  always_comb begin
    period = BASE_PERIOD - offset;
    if (offset > headroom) begin
      period = MIN_PERIOD;
    end
  end

endmodule

// File: rtl/frame_rate_controller.sv
// frame_rate_controller
// Sequencer between the game FSM and the frame-tick delay counter. It
// programs the counter reload (fps_count) from the current level, gates the
// counter enable/reload, and turns each enable_frame tick into a frame
// request for the game FSM.
//
// Optional build macro: FRAME_SKIP_COUNT_EN adds skip_count, a saturating
// count of overrun events (cleared on start and reset).
//
// Ports:
//   clk          in   1        system clock
//   resetn       in   1        asynchronous active-low reset
//   start        in   1        pulse: begin game at level 0 (IDLE only)
//   pause        in   1        level: hold frame ticks while high
//   level_up     in   1        pulse: increment level (saturating)
//   game_over    in   1        pulse: return to IDLE (highest priority)
//   enable_frame in   1        one-cycle tick from the delay counter
//   frame_ack    in   1        game FSM has consumed the frame
//   fps_count    out  32       reload value to the delay counter
//   delay_enable out  1        delay counter enable
//   delay_resetn out  1        active-low delay counter reload
//   frame_req    out  1        frame pending for the game FSM
//   level        out  LEVEL_W  current level
//   overrun      out  1        sticky: tick arrived while frame_req pending
//   state_dbg    out  2        current FSM state (frc_state_t encoding)
//   skip_count   out  8        overrun event count (FRAME_SKIP_COUNT_EN only)
//
// Frame handshake: frame_req acts as valid and frame_ack as ready. A frame
// is consumed on a cycle where frame_req=1 and frame_ack=1; frame_req then
// drops the next cycle unless a new tick arrives on that same cycle, in which
// case it stays high for the new frame. A tick with a frame still pending and
// not being consumed is an overrun; frames never queue. frame_ack with
// frame_req=0 has no effect. The handshake is only serviced in RUN.
module frame_rate_controller
  import frame_rate_pkg::*;
#(
  parameter logic [31:0] BASE_PERIOD = DEF_BASE_PERIOD,
  parameter logic [31:0] STEP        = DEF_STEP,
  parameter logic [31:0] MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int          MAX_LEVEL   = 15,
  parameter int          LEVEL_W     = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               pause,
  input  logic               level_up,
  input  logic               game_over,
  input  logic               enable_frame,
  input  logic               frame_ack,
  output logic [31:0]        fps_count,
  output logic               delay_enable,
  output logic               delay_resetn,
  output logic               frame_req,
  output logic [LEVEL_W-1:0] level,
  output logic               overrun,
  output logic [1:0]         state_dbg
`ifdef FRAME_SKIP_COUNT_EN
  ,
  output logic [7:0]         skip_count
`endif
);

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);

  frc_state_t  state;
  logic [31:0] lut_period;
  logic        level_inc;

  assign state_dbg = state;

  // Level increments are accepted while the game is live (RUN or PAUSED).
  assign level_inc = level_up && !game_over && (level != LEVEL_MAX) &&
                     ((state == ST_RUN) || (state == ST_PAUSED));

  period_lut #(
    .BASE_PERIOD(BASE_PERIOD),
    .STEP       (STEP),
    .MIN_PERIOD (MIN_PERIOD),
    .LEVEL_W    (LEVEL_W)
  ) u_period_lut (
    .level (level),
    .period(lut_period)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      level        <= '0;
      fps_count    <= BASE_PERIOD;
      delay_enable <= 1'b0;
      delay_resetn <= 1'b0;
      frame_req    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // fps_count follows the registered level, giving a two-cycle latency
      // from level_up; the counter picks it up at its next reload.
      fps_count <= lut_period;

      if (level_inc) begin
        level <= level + 1'b1;
      end

      if (game_over) begin
        state        <= ST_IDLE;
        delay_enable <= 1'b0;
        delay_resetn <= 1'b0;
        frame_req    <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            delay_enable <= 1'b0;
            delay_resetn <= 1'b0;
            frame_req    <= 1'b0;
            if (start) begin
              state     <= ST_LOAD;
              level     <= '0;
              overrun   <= 1'b0;
              // Level 0 period, present during LOAD so the counter loads it.
              fps_count <= BASE_PERIOD;
            end
          end

          ST_LOAD: begin
            state        <= ST_RUN;
            delay_enable <= 1'b1;
            delay_resetn <= 1'b1;
          end

          ST_RUN: begin
            if (enable_frame) begin
              if (frame_req && !frame_ack) begin
                overrun <= 1'b1;
              end
              frame_req <= 1'b1;
            end else if (frame_ack) begin
              frame_req <= 1'b0;
            end
            if (pause) begin
              state        <= ST_PAUSED;
              delay_enable <= 1'b0;
            end
          end

          ST_PAUSED: begin
            // Counter holds (reload released, enable low); ticks and acks
            // are not serviced here.
            if (!pause) begin
              state        <= ST_RUN;
              delay_enable <= 1'b1;
            end
          end

          default: begin
            state        <= ST_IDLE;
            delay_enable <= 1'b0;
            delay_resetn <= 1'b0;
            frame_req    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef FRAME_SKIP_COUNT_EN
  logic overrun_event;

  assign overrun_event = (state == ST_RUN) && !game_over && enable_frame &&
                         frame_req && !frame_ack;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skip_count <= 8'd0;
    end else if ((state == ST_IDLE) && start && !game_over) begin
      skip_count <= 8'd0;
    end else if (overrun_event && (skip_count != 8'hFF)) begin
      skip_count <= skip_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/frame_rate_controller.md
Name: frame_rate_controller

Overview:
Sequencer that configures and drives the frame-tick delay counter for the block stacker game. It computes the per-level reload value (fps_count), gates the counter's enable and reset, and converts each enable_frame pulse into a req/ack frame handshake to the game FSM. The game FSM raises level_up on each placed row to increase the frame rate. The block sits between the game FSM and the delay counter.

Parameters:
BASE_PERIOD, 3333332, reload value at level 0 (15 fps at 50 MHz); must be < 2^23
STEP, 208333, reload decrement per level
MIN_PERIOD, 833332, floor on reload value (about 60 fps)
MAX_LEVEL, 15, saturation value of level
LEVEL_W, 4, width of level; must satisfy 2^LEVEL_W > MAX_LEVEL

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  pulse: begin game at level 0
pause  in  1  level: hold frame ticks while high
level_up  in  1  pulse: increment level
game_over  in  1  pulse: stop, return to idle
enable_frame  in  1  one-cycle tick from delay counter
frame_ack  in  1  game FSM has consumed frame
fps_count  out  32  reload value to delay counter
delay_enable  out  1  delay counter enable
delay_resetn  out  1  active-low delay counter reload
frame_req  out  1  frame pending for game FSM
level  out  LEVEL_W  current level
overrun  out  1  sticky: a tick arrived while frame_req was still pending

Behaviour:
- Reset values (async, resetn=0): state=IDLE, level=0, fps_count=BASE_PERIOD, delay_enable=0, delay_resetn=0, frame_req=0, overrun=0. All outputs are registered.
- State machine: IDLE, LOAD, RUN, PAUSED.
- IDLE: delay_enable=0, delay_resetn=0, frame_req=0.
  - start=1 -> LOAD; level<=0; overrun<=0.
- LOAD (exactly 1 cycle): fps_count<=period(level); delay_resetn stays 0 so the counter loads; delay_enable=0. Next state is RUN.
- RUN: delay_resetn=1, delay_enable=1.
  - pause=1 -> PAUSED.
- PAUSED: delay_enable=0, delay_resetn=1 (counter holds its value); frame_req and level hold.
  - pause=0 -> RUN.
  - An enable_frame seen in PAUSED is ignored.
- game_over=1 in any state -> IDLE next cycle, with IDLE outputs. game_over has priority over start, pause and level_up.
- start while not IDLE is ignored.
- Frame handshake (RUN only):
  - enable_frame=1 with frame_req=0: frame_req<=1 next cycle.
  - enable_frame=1 with frame_req=1: overrun<=1; frame_req stays 1 (frames do not queue).
  - frame_ack=1 with frame_req=1: frame_req<=0 next cycle.
  - frame_ack and enable_frame in the same cycle: frame_req stays 1 (new frame); overrun is not set.
  - frame_ack while frame_req=0 is ignored.
- Level:
  - level_up in RUN or PAUSED: level<=level+1, saturating at MAX_LEVEL.
  - fps_count<=period(new level) on the following cycle (2-cycle latency from level_up). The new rate takes effect at the delay counter's next reload.
  - level_up and enable_frame in the same cycle: both processed.
- Period arithmetic:
  - period(L) = BASE_PERIOD - L*STEP in 32-bit unsigned.
  - If L*STEP > BASE_PERIOD - MIN_PERIOD, period = MIN_PERIOD. Compare before subtracting; no wrap.
- Reset mid-operation: all state returns to reset values immediately; no frame_req survives.

Optional Feature:
FRAME_SKIP_COUNT_EN
- Defined: adds output skip_count[7:0]. Increments (saturating at 255) on each overrun event; cleared on start and reset. overrun behaviour is unchanged.
- Undefined: no skip_count port and no counter logic.

Decomposition:
- Package frame_rate_pkg:
  - state enum (IDLE, LOAD, RUN, PAUSED)
  - default BASE_PERIOD, STEP, MIN_PERIOD constants
  - 50 MHz period constants for 10/15/60 fps
- Sub-module period_lut: combinational level -> clamped period using the compare-then-subtract rule, instantiated once.

Test Plan:
(Benches use BASE_PERIOD=20, STEP=4, MIN_PERIOD=6, MAX_LEVEL=15.)
1. Reset, then start pulse -> LOAD for 1 cycle with delay_resetn=0 and fps_count=20; then delay_enable=1 and delay_resetn=1; level=0.
2. enable_frame pulse, frame_ack 3 cycles later -> frame_req rises 1 cycle after the tick and falls 1 cycle after ack; overrun=0.
3. Two enable_frame pulses with no ack -> frame_req=1, overrun=1 after the second tick. If FRAME_SKIP_COUNT_EN is defined, skip_count=1.
4. Five level_up pulses -> fps_count goes 16, 12, 8, 6, 6; level=5. Then 12 more pulses -> level=15, fps_count=6.
5. pause=1 for 10 cycles with enable_frame pulsed inside the window -> delay_enable=0, no frame_req. pause=0 -> delay_enable=1.
6. game_over concurrent with level_up and enable_frame -> IDLE next cycle, frame_req=0, level unchanged. Assert resetn=0 mid-RUN -> all outputs at reset values asynchronously.
